seq_dtree_eval: RTL and testbench
=================================

SEQ_DTREE_EVAL -- requirements
Module: seq_dtree_eval

Interface
REQ-001 SHALL have parameter N_FEAT, default 8, number of input features.
REQ-002 SHALL have parameter FEAT_W, default 8, bits per feature.
REQ-003 SHALL have parameter N_NODES, default 64, node-table entries; IDX_W = clog2(N_NODES).
REQ-004 SHALL have parameter CLASS_W, default 5, class-label width (CLASS_W <= IDX_W).
REQ-005 SHALL have parameter MAX_DEPTH, default 16, node visits allowed per inference.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port cfg_we, input, 1, node-table write strobe.
REQ-009 SHALL have port cfg_addr, input, IDX_W, node index to write.
REQ-010 SHALL have port cfg_node, input, NODE_W, packed node word {is_leaf, feat_idx, shift, thr, left_or_class, right}.
REQ-011 SHALL have port in_valid, input, 1, feature vector valid.
REQ-012 SHALL have port in_ready, output, 1, block accepts a vector.
REQ-013 SHALL have port in_feat, input, N_FEAT*FEAT_W, features; feature i at bits [i*FEAT_W +: FEAT_W].
REQ-014 SHALL have port out_valid, output, 1, result valid.
REQ-015 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-016 SHALL have port out_class, output, CLASS_W, predicted class.
REQ-017 SHALL have port out_err, output, 1, inference aborted (REQ-025).

Function
REQ-018 SHALL implement FSM states IDLE, WALK, DONE.
REQ-019 SHALL drive in_ready = (state==IDLE) && !cfg_we; a config write in IDLE takes priority and blocks acceptance that cycle.
REQ-020 SHALL write cfg_node to entry cfg_addr on a clock edge only when cfg_we is high and state is IDLE; writes in WALK/DONE are dropped.
REQ-021 SHALL, on in_valid&&in_ready, register in_feat, set node pointer to 0, clear depth counter, enter WALK.
REQ-022 SHALL in WALK evaluate one node per cycle: internal node goes to left if (feature[feat_idx] >> shift) <= thr, else right; unsigned compare, thr is FEAT_W bits.
REQ-023 SHALL on a leaf load out_class = left_or_class[CLASS_W-1:0], out_err=0, enter DONE.
REQ-024 SHALL make latency exactly P cycles from accepting edge to out_valid rising, P = nodes on path including leaf.
REQ-025 SHALL abort with out_class=0, out_err=1, enter DONE when: feat_idx >= N_FEAT; child index >= N_NODES; or MAX_DEPTH nodes visited without reaching a leaf.
REQ-026 SHALL hold out_valid=1 with out_class/out_err stable in DONE until out_valid&&out_ready, then return to IDLE; in_ready rises in the following cycle.
REQ-027 SHALL keep captured features stable for the whole inference regardless of in_feat changes.

Reset
REQ-028 SHALL on rst asynchronously force state IDLE, out_valid=0, out_class=0, out_err=0, node pointer and depth counter 0.
REQ-029 SHALL on rst set every node-table entry to leaf with class 0.
REQ-030 SHALL on rst mid-inference discard the inference with no output produced.

Structure
REQ-031 SHALL place node field widths, the NODE_W function, the node struct and the FSM state enum in shared package dtree_pkg.
REQ-032 SHALL isolate the shift, compare and child-select logic in sub-module dtree_node_cmp (node word + feature in, next index + leaf flag out).
REQ-033 SHALL hold the node table in flops (no SRAM macro); one combinational read port.

Verification
REQ-034 Reset, then infer with no config -> out_valid 1 cycle after acceptance, class 0, err 0.
REQ-035 Root: feat 2, shift 5, thr 3, left 1, right 2; node1 leaf 13; node2 leaf 6. Input X2=0x7F -> class 13, latency 2; X2=0x80 -> class 6, latency 2.
REQ-036 Node0 right=0 self-loop, input taking right -> out_err 1, class 0 after exactly MAX_DEPTH=16 cycles.
REQ-037 feat_idx=9 with N_FEAT=8 -> err 1 at latency 1; child index 70 with N_NODES=64 -> err 1.
REQ-038 Hold out_ready=0 for 5 cycles in DONE, pulse cfg_we meanwhile -> output stable, write dropped, in_ready low until the cycle after the handshake.
REQ-039 Assert rst during WALK at depth 3 -> out_valid never rises, state IDLE, table reverts to leaf class 0.

Source files
------------

// File: rtl/dtree_pkg.sv
// dtree_pkg: node-word field widths, node layout, and FSM states for the tree evaluator
package dtree_pkg;
  function automatic int fi_w(int n_feat);
    return $clog2(n_feat) + 1;
  endfunction
  function automatic int sh_w(int feat_w);
    return $clog2(feat_w) + 1;
  endfunction
  function automatic int ch_w(int n_nodes);
    return $clog2(n_nodes) + 1;
  endfunction
  function automatic int node_w(int n_feat, int feat_w, int n_nodes);
    return 1 + fi_w(n_feat) + sh_w(feat_w) + feat_w + 2 * ch_w(n_nodes);
  endfunction
  localparam int DEF_FI_W = fi_w(8);
  localparam int DEF_SH_W = sh_w(8);
  localparam int DEF_CH_W = ch_w(64);
  typedef struct packed {
    logic                is_leaf;
    logic [DEF_FI_W-1:0] feat_idx;
    logic [DEF_SH_W-1:0] shift;
    logic [7:0]          thr;
    logic [DEF_CH_W-1:0] left_or_class;
    logic [DEF_CH_W-1:0] right;
  } node_t;
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
endpackage

// File: rtl/dtree_node_cmp.sv
// dtree_node_cmp: decodes one node word, compares the shifted feature and picks the child
module dtree_node_cmp import dtree_pkg::*; #(
  parameter int N_FEAT = 8,
  parameter int FEAT_W = 8,
  parameter int N_NODES = 64,
  parameter int CLASS_W = 5,
  localparam int IDX_W = $clog2(N_NODES),
  localparam int FI_W = fi_w(N_FEAT),
  localparam int SH_W = sh_w(FEAT_W),
  localparam int CH_W = ch_w(N_NODES),
  localparam int NODE_W = node_w(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic [NODE_W-1:0]        node,
  input  logic [N_FEAT*FEAT_W-1:0] feat,
  output logic                     leaf,
  output logic                     bad,
  output logic [IDX_W-1:0]         nxt,
  output logic [CLASS_W-1:0]       cls
);
  localparam int FS_W = N_FEAT > 1 ? $clog2(N_FEAT) : 1;
  logic [FI_W-1:0] fi;
  logic [SH_W-1:0] sh;
  logic [FEAT_W-1:0] thr, fv;
  logic [CH_W-1:0] lc, rc, ch;
  logic bad_f;
  logic [FEAT_W-1:0] fa [N_FEAT];
  assign {leaf, fi, sh, thr, lc, rc} = node;
  for (genvar i = 0; i < N_FEAT; i++) begin : g_f
    assign fa[i] = feat[i*FEAT_W +: FEAT_W];
  end
  // Out-of-range feature or child indices are flagged rather than wrapped
  always_comb begin
    bad_f = fi >= FI_W'(N_FEAT);
    fv = bad_f ? '0 : fa[fi[FS_W-1:0]];
    ch = ((fv >> sh) <= thr) ? lc : rc;
    bad = bad_f || (ch >= CH_W'(N_NODES));
    nxt = ch[IDX_W-1:0];
    cls = lc[CLASS_W-1:0];
  end
endmodule

// File: rtl/seq_dtree_eval.sv
// seq_dtree_eval: walks a flop-based decision-tree table one node per cycle per feature vector
module seq_dtree_eval import dtree_pkg::*; #(
  parameter int N_FEAT = 8,
  parameter int FEAT_W = 8,
  parameter int N_NODES = 64,
  parameter int CLASS_W = 5,
  parameter int MAX_DEPTH = 16,
  localparam int IDX_W = $clog2(N_NODES),
  localparam int NODE_W = node_w(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  logic [NODE_W-1:0]        cfg_node,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err
);
  localparam int DEP_W = $clog2(MAX_DEPTH) + 1;
  state_t state;
  logic [NODE_W-1:0] tbl [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] feat;
  logic [IDX_W-1:0] ptr, nxt;
  logic [DEP_W-1:0] depth;
  logic leaf, bad;
  logic [CLASS_W-1:0] cls;
  assign in_ready = (state == IDLE) && !cfg_we;
  dtree_node_cmp #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES), .CLASS_W(CLASS_W)) u_cmp (
    .node(tbl[ptr]),
    .feat(feat),
    .leaf(leaf),
    .bad(bad),
    .nxt(nxt),
    .cls(cls)
  );
  // Node table: resets to all class-0 leaves, writable only while idle
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int k = 0; k < N_NODES; k++) tbl[k] <= {1'b1, {(NODE_W-1){1'b0}}};
    else if (cfg_we && state == IDLE)
      tbl[cfg_addr] <= cfg_node;
  // Inference FSM: accept, walk one node per cycle, hold result until taken
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_class <= '0;
      out_err <= 1'b0;
      ptr <= '0;
      depth <= '0;
      feat <= '0;
    end else
      case (state)
        IDLE:
          if (in_valid && in_ready) begin
            feat <= in_feat;
            ptr <= '0;
            depth <= '0;
            state <= WALK;
          end
        WALK:
          if (leaf) begin
            out_class <= cls;
            out_err <= 1'b0;
            out_valid <= 1'b1;
            state <= DONE;
          end else if (bad || depth == DEP_W'(MAX_DEPTH - 1)) begin
            out_class <= '0;
            out_err <= 1'b1;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            ptr <= nxt;
            depth <= depth + 1'b1;
          end
        default:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_seq_dtree_eval.sv
// tb_seq_dtree_eval: randomized and directed checks of seq_dtree_eval against a path-walking model
module tb_seq_dtree_eval;
  import dtree_pkg::*;
  localparam int NF = 8, FW = 8, NN = 64, CW = 5, MD = 16, IW = 6;
  localparam int NW = node_w(NF, FW, NN);
  logic clk = 0, rst = 0, cfg_we = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, out_err;
  logic [IW-1:0] cfg_addr = '0;
  logic [NW-1:0] cfg_node = '0;
  logic [NF*FW-1:0] in_feat = '0;
  logic [CW-1:0] out_class;
  int n_chk = 0, n_fail = 0;
  node_t tm [NN];
  seq_dtree_eval dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_node(cfg_node),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic node_t mk(int lf, int fi, int sh, int thr, int l, int r);
    node_t n;
    n.is_leaf = lf[0];
    n.feat_idx = 4'(fi);
    n.shift = 4'(sh);
    n.thr = 8'(thr);
    n.left_or_class = 7'(l);
    n.right = 7'(r);
    return n;
  endfunction
  task automatic model_reset;
    for (int k = 0; k < NN; k++) tm[k] = mk(1, 0, 0, 0, 0, 0);
  endtask
  function automatic void model(logic [63:0] f, output int c, output int e, output int lat);
    int p, fi, ch;
    node_t n;
    p = 0;
    c = 0; e = 1; lat = MD;
    for (int d = 1; d <= MD; d++) begin
      n = tm[p];
      fi = int'(n.feat_idx);
      if (n.is_leaf) begin
        c = int'(n.left_or_class) % 32; e = 0; lat = d;
        return;
      end
      if (fi >= NF) begin
        lat = d;
        return;
      end
      ch = ((f[fi*FW +: FW] >> n.shift) <= n.thr) ? int'(n.left_or_class) : int'(n.right);
      if (ch >= NN || d == MD) begin
        lat = d;
        return;
      end
      p = ch;
    end
  endfunction
  task automatic cfg(int a, node_t n);
    @(posedge clk); #1;
    cfg_we = 1; cfg_addr = IW'(a); cfg_node = n;
    @(posedge clk); #1;
    cfg_we = 0;
    tm[a] = n;
  endtask
  task automatic run(string tag, logic [63:0] f, int hold, bit poke);
    int c, e, lat, got_lat;
    logic [CW-1:0] cls0;
    logic err0;
    model(f, c, e, lat);
    @(posedge clk); #1;
    in_valid = 1; in_feat = f;
    @(posedge clk); #1;
    in_valid = 0; in_feat = {$urandom(), $urandom()};
    got_lat = 0;
    while (!out_valid && got_lat < 40) begin
      @(posedge clk); #1;
      got_lat++;
      in_feat = {$urandom(), $urandom()};
    end
    check({tag, "_lat"}, got_lat, lat);
    check({tag, "_class"}, 32'(out_class), c);
    check({tag, "_err"}, 32'(out_err), e);
    cls0 = out_class; err0 = out_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      cfg_we = poke && k == 1; cfg_addr = 1; cfg_node = mk(1, 0, 0, 0, 31, 0);
      check({tag, "_hold_v"}, 32'(out_valid), 1);
      check({tag, "_hold_c"}, 32'({err0, cls0}), 32'({out_err, out_class}));
      check({tag, "_hold_rdy"}, 32'(in_ready), 0);
    end
    cfg_we = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check({tag, "_drop_v"}, 32'(out_valid), 0);
    check({tag, "_rdy"}, 32'(in_ready), 1);
  endtask
  initial begin
    bit seen;
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v", 32'(out_valid), 0);
    check("rst_c", 32'(out_class), 0);
    check("rst_e", 32'(out_err), 0);
    check("rst_rdy", 32'(in_ready), 1);
    rst = 0;
    run("noconf", {$urandom(), $urandom()}, 0, 0);
    cfg(0, mk(0, 2, 5, 3, 1, 2));
    cfg(1, mk(1, 0, 0, 0, 13, 0));
    cfg(2, mk(1, 0, 0, 0, 6, 0));
    run("x7f", 64'h7F << 16, 1, 0);
    run("x80", 64'h80 << 16, 2, 0);
    run("hold", 64'h7F << 16, 5, 1);
    run("afterpoke", 64'h10 << 16, 0, 0);
    cfg(0, mk(0, 0, 0, 0, 1, 0));
    run("loop", 64'h5, 1, 0);
    cfg(0, mk(0, 9, 0, 255, 1, 2));
    run("badfeat", {$urandom(), $urandom()}, 0, 0);
    cfg(0, mk(0, 0, 0, 255, 70, 1));
    run("badchild", {$urandom(), $urandom()}, 0, 0);
    cfg(0, mk(0, 0, 0, 0, 1, 0));
    @(posedge clk); #1;
    in_valid = 1; in_feat = 64'h5;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    check("mid_rst_v", 32'(out_valid), 0);
    check("mid_rst_rdy", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("mid_rst_quiet", 32'(seen), 0);
    run("after_rst", 64'h5, 0, 0);
    for (int it = 0; it < 48; it++) begin
      if (it % 8 == 0)
        for (int a = 0; a < NN; a++)
          cfg(a, mk(int'($urandom_range(0, 2) == 0), int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 65)), int'($urandom_range(0, 65))));
      run("rnd", {$urandom(), $urandom()}, int'($urandom_range(0, 3)), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
